// File: rtl/fetch_block_sequencer_if.sv
// fetch_block_sequencer_if: request/grant plus in-order read-response bus to instruction memory
interface fetch_block_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic req;
  logic [ADDR_W-1:0] addr;
  logic gnt;
  logic rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_block_sequencer.sv
// fetch_block_sequencer: fills a NUM_INSTR-word instruction block from memory and hands it to the fetch stage
module fetch_block_sequencer #(
  parameter int NUM_INSTR = 16,
  parameter int ADDR_W = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic stop,
  input  logic redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic slot_done,
  fetch_block_sequencer_if.master mem,
  output logic [NUM_INSTR-1:0][31:0] block_data,
  output logic block_vld,
  output logic [ADDR_W-1:0] block_base,
  output logic fetch_stall,
  output logic busy
);
  localparam int LW = $clog2(NUM_INSTR);
  localparam int CW = LW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_INSTR - 1);
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'(NUM_INSTR - 1);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, DELIVER, RUN} state_t;
  state_t state;
  logic [CW-1:0] req_cnt, rsp_cnt;
  logic [OW-1:0] outstanding;
  logic to_idle, grant, rv, abort;
  always_comb begin
    mem.req = state == FETCH && req_cnt <= LAST && outstanding < OW'(MAX_OUTSTANDING);
    mem.addr = block_base + ADDR_W'(req_cnt);
    grant = mem.req && mem.gnt;
    rv = mem.rvalid && outstanding != '0;
    abort = stop || redirect;
    block_vld = state == DELIVER && !abort;
    fetch_stall = state != RUN;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req_cnt <= '0;
      rsp_cnt <= '0;
      outstanding <= '0;
      block_base <= '0;
      block_data <= '0;
      to_idle <= 1'b0;
    end else begin
      outstanding <= outstanding + OW'(grant) - OW'(rv);
      if (grant) req_cnt <= req_cnt + CW'(1);
      case (state)
        IDLE:
          if (start) begin
            block_base <= start_addr & MASK;
            req_cnt <= '0;
            rsp_cnt <= '0;
            state <= FETCH;
          end
        DRAIN:
          if (stop) to_idle <= 1'b1;
          else if (redirect) begin
            block_base <= redirect_addr & MASK;
            to_idle <= 1'b0;
          end else if (outstanding == '0) begin
            req_cnt <= '0;
            rsp_cnt <= '0;
            state <= to_idle ? IDLE : FETCH;
          end
        default:
          if (abort) begin
            if (!stop) block_base <= redirect_addr & MASK;
            req_cnt <= '0;
            rsp_cnt <= '0;
            to_idle <= stop;
            // responses already granted must be swallowed before the next fetch starts
            state <= (outstanding != '0 || grant) ? DRAIN : stop ? IDLE : FETCH;
          end else if (state == FETCH) begin
            if (rv) begin
              block_data[rsp_cnt[LW-1:0]] <= mem.rdata;
              rsp_cnt <= rsp_cnt + CW'(1);
              if (rsp_cnt == LAST) state <= DELIVER;
            end
          end else if (state == DELIVER) state <= RUN;
          else if (slot_done) begin
            block_base <= block_base + ADDR_W'(NUM_INSTR);
            req_cnt <= '0;
            rsp_cnt <= '0;
            state <= FETCH;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_block_sequencer.sv
// tb_fetch_block_sequencer: directed and randomized checks against a block-level memory model
module tb_fetch_block_sequencer;
  logic clk = 1'b1;
  logic rst_n, start, stop, redirect, slot_done;
  logic [31:0] start_addr, redirect_addr, block_base;
  logic [15:0][31:0] block_data;
  logic block_vld, fetch_stall, busy;
  fetch_block_sequencer_if #(.ADDR_W(32)) mem ();
  fetch_block_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .stop(stop),
    .redirect(redirect), .redirect_addr(redirect_addr), .slot_done(slot_done), .mem(mem),
    .block_data(block_data), .block_vld(block_vld), .block_base(block_base),
    .fetch_stall(fetch_stall), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] a; int due; } rq_t;
  rq_t q[$];
  logic [31:0] glog[$];
  int cyc = 0, gnt_pct = 100, lat_min = 1, lat_max = 1, gnt_hold = 0, max_out = 0;
  int n_vec = 0, n_err = 0;
  logic [31:0] salt = '0;
  logic flush = 1'b0, force_rv = 1'b0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a + 32'h100 + salt;
  endfunction
  function automatic logic [511:0] blk(input logic [31:0] b);
    logic [511:0] r = '0;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = word(b + 32'(i));
    return r;
  endfunction
  // memory: grants and responses are decided at negedge for the following posedge
  always @(negedge clk) begin
    cyc++;
    mem.rvalid = 1'b0;
    mem.rdata = '0;
    if (flush) q.delete();
    if (force_rv) begin
      mem.rvalid = 1'b1;
      mem.rdata = 32'hDEAD_BEEF;
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      mem.rvalid = 1'b1;
      mem.rdata = word(q[0].a);
      void'(q.pop_front());
    end
    if (gnt_hold > 0) begin
      mem.gnt = 1'b0;
      gnt_hold--;
    end else mem.gnt = ($urandom_range(99) < gnt_pct);
    if (mem.req === 1'b1 && mem.gnt) begin
      q.push_back('{mem.addr, cyc + int'($urandom_range(lat_max, lat_min))});
      glog.push_back(mem.addr);
    end
    if (q.size() > max_out) max_out = q.size();
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, " req"}, mem.req, 0);
    chk({tag, " addr"}, mem.addr, 0);
    chk({tag, " vld"}, block_vld, 0);
    chk({tag, " stall"}, fetch_stall, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " base"}, block_base, 0);
    chk({tag, " data"}, block_data, 0);
  endtask
  task automatic wait_block(input logic [31:0] base, input string tag);
    int k = 0;
    logic [511:0] g = '0, e = '0;
    while (block_vld !== 1'b1 && k < 500) begin
      tick();
      k++;
    end
    chk({tag, " vld"}, block_vld, 1);
    chk({tag, " stall@vld"}, fetch_stall, 1);
    chk({tag, " base"}, block_base, base);
    chk({tag, " data"}, block_data, blk(base));
    chk({tag, " grants"}, glog.size(), 16);
    for (int i = 0; i < 16; i++) begin
      e[i*32 +: 32] = base + 32'(i);
      if (i < glog.size()) g[i*32 +: 32] = glog[i];
    end
    chk({tag, " addr seq"}, g, e);
    tick();
    chk({tag, " vld pulse"}, block_vld, 0);
    chk({tag, " stall run"}, fetch_stall, 0);
  endtask
  initial begin
    int k;
    logic [31:0] cur, tgt;
    rst_n = 0; start = 0; stop = 0; redirect = 0; slot_done = 0;
    start_addr = '0; redirect_addr = '0;
    tick();
    tick();
    reset_vals("reset");
    rst_n = 1;
    tick();
    glog.delete(); start_addr = 32'h13; start = 1; tick(); start = 0;
    wait_block(32'h10, "first");
    chk("first d0", block_data[0], 32'h110);
    chk("first d15", block_data[15], 32'h11F);
    glog.delete(); slot_done = 1; tick(); slot_done = 0;
    wait_block(32'h20, "next");
    glog.delete(); redirect_addr = 32'hFFFF_FFF5; redirect = 1; tick(); redirect = 0;
    wait_block(32'hFFFF_FFF0, "top");
    glog.delete(); slot_done = 1; tick(); slot_done = 0;
    wait_block(32'h0, "wrap");
    max_out = 0; lat_min = 6; lat_max = 6; gnt_hold = 6;
    glog.delete(); slot_done = 1; tick(); slot_done = 0;
    wait_block(32'h10, "slow");
    chk("slow max_out", max_out, 4);
    lat_min = 3; lat_max = 3;
    glog.delete(); slot_done = 1; tick(); slot_done = 0;
    k = 0;
    while (glog.size() < 6 && k < 100) begin tick(); k++; end
    redirect_addr = 32'h80; redirect = 1; tick(); redirect = 0;
    chk("drain req", mem.req, 0);
    glog.delete();
    wait_block(32'h80, "redir");
    glog.delete(); redirect_addr = 32'h345; redirect = 1; slot_done = 1; tick();
    redirect = 0; slot_done = 0;
    chk("prio base", block_base, 32'h340);
    wait_block(32'h340, "prio");
    glog.delete(); slot_done = 1; tick(); slot_done = 0;
    k = 0;
    while (glog.size() < 3 && k < 100) begin tick(); k++; end
    stop = 1; tick(); stop = 0;
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    chk("stop busy", busy, 0);
    chk("stop stall", fetch_stall, 1);
    chk("stop req", mem.req, 0);
    glog.delete(); start_addr = 32'h407; start = 1; tick(); start = 0;
    wait_block(32'h400, "restart");
    cur = 32'h400;
    for (int r = 0; r < 8; r++) begin
      salt = $urandom;
      gnt_pct = $urandom_range(100, 30);
      lat_min = 1;
      lat_max = $urandom_range(8, 1);
      tgt = $urandom;
      glog.delete();
      if (r % 2 == 0) begin
        redirect_addr = tgt; redirect = 1; cur = tgt & ~32'hF;
      end else begin
        slot_done = 1; cur = cur + 32'd16;
      end
      tick(); redirect = 0; slot_done = 0;
      if (r % 3 == 1) begin
        k = 0;
        tgt = 32'($urandom_range(10, 1));
        while (glog.size() < tgt && k < 300) begin tick(); k++; end
        tgt = $urandom;
        redirect_addr = tgt; redirect = 1; tick(); redirect = 0;
        glog.delete();
        cur = tgt & ~32'hF;
      end
      wait_block(cur, $sformatf("rand%0d", r));
    end
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    glog.delete(); slot_done = 1; tick(); slot_done = 0;
    k = 0;
    while (glog.size() < 5 && k < 100) begin tick(); k++; end
    rst_n = 0; tick();
    reset_vals("midreset");
    rst_n = 1; flush = 1; tick(); flush = 0;
    force_rv = 1; tick(); tick(); force_rv = 0; tick();
    chk("stray data", block_data, 0);
    chk("stray busy", busy, 0);
    chk("stray req", mem.req, 0);
    salt = '0; lat_min = 1; lat_max = 2;
    glog.delete(); start_addr = 32'h5A3; start = 1; tick(); start = 0;
    wait_block(32'h5A0, "post");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_block_sequencer.md
Name: fetch_block_sequencer

Overview:
Controller that feeds the 16-entry instruction block buffer of the fetch stage.
- Fetches 16 consecutive 32-bit words from instruction memory over a request/grant + in-order response interface.
- Assembles them into one block and presents it with a one-cycle valid pulse.
- Holds the fetch stage stalled until the block is loaded, then refills on block exhaustion or on a branch redirect.

Parameters:
NUM_INSTR, 16, words per block; power of two.
ADDR_W, 32, word-address width.
MAX_OUTSTANDING, 4, maximum granted-but-unanswered memory requests.

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
start  input  1  begin fetching at start_addr; honoured only in IDLE
start_addr  input  ADDR_W  word address of first block; low log2(NUM_INSTR) bits ignored
stop  input  1  abandon fetching and return to IDLE
redirect  input  1  branch taken; refetch at redirect_addr
redirect_addr  input  ADDR_W  target block word address; low bits ignored
slot_done  input  1  fetch stage consumed its last block slot
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  word address of the current request
mem_gnt  input  1  request accepted this cycle when mem_req && mem_gnt
mem_rvalid  input  1  read data valid; responses in request order, at least 1 cycle after grant
mem_rdata  input  32  read data
block_data  output  32 x NUM_INSTR  assembled block; entry i = word at block_base+i
block_vld  output  1  one-cycle pulse: block_data complete and stable
block_base  output  ADDR_W  aligned base of the current/pending block
fetch_stall  output  1  drives fetch-stage halt; 0 only in RUN
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; req_cnt=rsp_cnt=outstanding=0; block_base=0; block_data all 0; mem_req=0; mem_addr=0; block_vld=0; fetch_stall=1; busy=0. Reset mid-fetch discards everything; late responses after reset are ignored because outstanding=0.
- States: IDLE, FETCH, DRAIN, DELIVER, RUN.
- IDLE: on start, block_base <= start_addr with low bits cleared; req_cnt, rsp_cnt <= 0; go to FETCH.
- FETCH:
  - mem_req=1 while req_cnt<NUM_INSTR and outstanding<MAX_OUTSTANDING.
  - mem_addr = block_base + req_cnt, mod 2^ADDR_W.
  - Grant: req_cnt+1, outstanding+1.
  - mem_rvalid: block_data[rsp_cnt] <= mem_rdata; rsp_cnt+1; outstanding-1.
  - Grant and rvalid in the same cycle leave outstanding unchanged.
  - When the 16th response is captured, go to DELIVER.
- DELIVER: block_vld=1 for exactly one cycle, then RUN. First block_vld is 1 cycle after the last response.
- RUN: fetch_stall=0; mem_req=0. On slot_done: block_base <= block_base+NUM_INSTR (wraps at 2^ADDR_W); clear counters; go to FETCH.
- redirect in FETCH, DELIVER or RUN:
  - block_base <= aligned redirect_addr; req_cnt <= 0.
  - If outstanding>0 (or a grant occurs this cycle), go to DRAIN; otherwise go to FETCH with rsp_cnt <= 0.
  - A block_vld in DELIVER that same cycle is suppressed.
- DRAIN: mem_req=0. Consume responses without writing block_data until outstanding=0, then FETCH with rsp_cnt <= 0. A further redirect in DRAIN overwrites block_base and stays in DRAIN.
- stop in any non-IDLE state: behaves like redirect but ends in IDLE (via DRAIN if outstanding>0). block_data is retained.
- Priority: stop > redirect > slot_done. start outside IDLE is ignored.
- mem_rvalid with outstanding=0 is ignored and never underflows the counter.
- block_data changes only during FETCH captures; it is stable from block_vld until the next FETCH capture.

Test Plan:
- Reset, start=1 with start_addr=0x0000_0013, memory returns data=addr+0x100 with 1-cycle latency and gnt=1 -> mem_addr sequence 0x10..0x1F; block_vld pulses once; block_data[0]=0x110, block_data[15]=0x11F; block_base=0x10; fetch_stall falls the cycle after block_vld.
- In RUN, slot_done=1 -> mem_addr 0x20..0x2F; block_vld again; block_base=0x20. Repeat with block_base=0xFFFF_FFF0 -> next block_base=0x0000_0000.
- mem_gnt held low 5 cycles, then response latency of 6 cycles -> outstanding never exceeds 4; mem_req deasserts at outstanding=4; block still correct and in order.
- redirect to 0x80 after 6 grants with 3 responses outstanding -> enter DRAIN; 3 responses discarded; then fetch 0x80..0x8F; block_data holds only 0x180..0x18F.
- redirect and slot_done in the same RUN cycle -> block_base=redirect target, not base+16. stop during FETCH -> IDLE after drain; busy=0; a later start is accepted.
- Synchronous reset asserted mid-FETCH with responses in flight -> next cycle all outputs at reset values; stray mem_rvalid ignored; block_data stays 0.
